pipe_hazard_ctrl: RTL

- Pipeline control unit that consumes the EX/MEM register outputs (branch/jump controls, zero, pc_4, busA, imm26, MemRead/MemWrite).
- Resolves control transfers in MEM, producing the PC redirect plus the per-stage write-enable and kill_control inputs of IF/ID, ID/EX, EX/MEM and MEM/WB.
- Detects load-use hazards from ID/EX versus IF/ID.
- Runs the data-memory req/ready handshake, including a stall FSM with a timeout watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/branch_target_unit.sv | 48 ++++
 rtl/pipe_hazard_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/control unit.
//   state_e  : control FSM encoding (START, RUN, MEM_WAIT, ERR)
//   PC_W     : word-PC width
//   REG_W    : register-specifier width
//   REG_ZERO : hard-wired zero register, never a hazard source
package pipe_ctrl_pkg;

  localparam int PC_W  = 30;
  localparam int REG_W = 5;

  localparam logic [0:REG_W-1] REG_ZERO = '0;

  typedef enum logic [1:0] {
    START    = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_e;

endpackage

// File: rtl/branch_target_unit.sv
// Combinational control-transfer resolution for the instruction in EX/MEM.
// Ports:
//   pc_4        : word PC+4 of the EX/MEM instruction
//   jr_target   : JumpR target (upper 30 bits of busA)
//   imm26       : EX/MEM immediate field
//   zero        : EX/MEM zero flag
//   BranchEQZ, BranchNEZ, Jump, JumpR, JumpAL : transfer controls
//   taken       : a control transfer is requested
//   redirect_pc : transfer target, or pc_4 when nothing is taken
module branch_target_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [0:PC_W-1] pc_4,
  input  logic [0:PC_W-1] jr_target,
  input  logic [0:25]     imm26,
  input  logic            zero,
  input  logic            BranchEQZ,
  input  logic            BranchNEZ,
  input  logic            Jump,
  input  logic            JumpR,
  input  logic            JumpAL,
  output logic            taken,
  output logic [0:PC_W-1] redirect_pc
);

  logic            br_taken;
  logic [0:PC_W-1] jump_off;
  logic [0:PC_W-1] branch_off;

  // Sign-extend the 26-bit jump field and the low 16-bit branch field.
  assign jump_off   = {{(PC_W-26){imm26[0]}}, imm26};
  assign branch_off = {{(PC_W-16){imm26[10]}}, imm26[10:25]};

  assign br_taken = (BranchEQZ & zero) | (BranchNEZ & ~zero);
  assign taken    = br_taken | Jump | JumpAL | JumpR;

  always_comb begin
    redirect_pc = pc_4;
    if (JumpR) begin
      redirect_pc = jr_target;
    end else if (Jump | JumpAL) begin
      redirect_pc = pc_4 + jump_off;
    end else if (br_taken) begin
      redirect_pc = pc_4 + branch_off;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: resolves EX/MEM control transfers, detects load-use
// hazards between ID/EX and IF/ID, and runs the data-memory req/ready
// handshake with a stall FSM and timeout watchdog.
// Ports:
//   clk, rst (async, active-low)
//   pc_4, busA, imm26, zero, Branch*/Jump* : EX/MEM transfer inputs
//   MemRead, MemWrite                      : EX/MEM memory op
//   idex_MemRead, idex_DestReg             : load in ID/EX
//   ifid_rs1, ifid_rs2, ifid_uses_rs2      : IF/ID sources
//   dmem_ready / dmem_req                  : data-memory handshake
//   redirect_valid, redirect_pc            : PC redirect
//   *_we, *_kill                           : stage enables / kill controls
//   mem_error                              : sticky timeout flag
// Parameters: MEM_TIMEOUT (2..255), CNT_W (wait counter width).
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating perf counters
// perf_stall_cnt, perf_flush_cnt, perf_luse_cnt.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [0:PC_W-1]  pc_4,
  input  logic [0:31]      busA,
  input  logic [0:25]      imm26,
  input  logic             zero,
  input  logic             BranchEQZ,
  input  logic             BranchNEZ,
  input  logic             Jump,
  input  logic             JumpR,
  input  logic             JumpAL,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             idex_MemRead,
  input  logic [0:REG_W-1] idex_DestReg,
  input  logic [0:REG_W-1] ifid_rs1,
  input  logic [0:REG_W-1] ifid_rs2,
  input  logic             ifid_uses_rs2,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             redirect_valid,
  output logic [0:PC_W-1]  redirect_pc,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_kill,
  output logic             idex_kill,
  output logic             exmem_kill,
  output logic             memwb_kill,
  output logic             mem_error
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [0:31]      perf_stall_cnt,
  output logic [0:31]      perf_flush_cnt,
  output logic [0:31]      perf_luse_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             mem_error_q, mem_error_d;
  logic             memop, active, stall, luse, taken, luse_fire;
  logic             unused_busa_lsbs;

  // JumpR targets are word addresses; the byte-offset bits are dropped.
  assign unused_busa_lsbs = ^busA[30:31];

  branch_target_unit u_btu (
    .pc_4        (pc_4),
    .jr_target   (busA[0:29]),
    .imm26       (imm26),
    .zero        (zero),
    .BranchEQZ   (BranchEQZ),
    .BranchNEZ   (BranchNEZ),
    .Jump        (Jump),
    .JumpR       (JumpR),
    .JumpAL      (JumpAL),
    .taken       (taken),
    .redirect_pc (redirect_pc)
  );

  assign memop  = MemRead | MemWrite;
  assign active = (state_q == RUN) || (state_q == MEM_WAIT);
  // state_q resets asynchronously, so the request drops the moment rst falls.
  assign dmem_req  = active & memop;
  assign stall     = dmem_req & ~dmem_ready;
  assign mem_error = mem_error_q;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  assign luse = idex_MemRead && (idex_DestReg != REG_ZERO) &&
                ((idex_DestReg == ifid_rs1) ||
                 (ifid_uses_rs2 && (idex_DestReg == ifid_rs2)));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= START;
      cnt_q       <= '0;
      mem_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_error_q <= mem_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_error_d = mem_error_q;
    case (state_q)
      START: state_d = RUN;
      RUN: begin
        if (stall) begin
          state_d = MEM_WAIT;
          cnt_d   = '0;
        end
      end
      MEM_WAIT: begin
        if (!stall) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(MEM_TIMEOUT - 1)) begin
            state_d     = ERR;
            mem_error_d = 1'b1;
          end
        end
      end
      default: state_d = ERR;
    endcase
  end

  // Output logic. The completion cycle of a wait releases any transfer that
  // was deferred behind the memory op, so redirects are honoured in both
  // RUN and MEM_WAIT once the stall clears.
  always_comb begin
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    idex_we        = 1'b1;
    exmem_we       = 1'b1;
    memwb_we       = 1'b1;
    ifid_kill      = 1'b0;
    idex_kill      = 1'b0;
    exmem_kill     = 1'b0;
    memwb_kill     = 1'b0;
    redirect_valid = 1'b0;
    luse_fire      = 1'b0;
    case (state_q)
      START: begin
        ifid_kill  = 1'b1;
        idex_kill  = 1'b1;
        exmem_kill = 1'b1;
        memwb_kill = 1'b1;
      end
      ERR: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        memwb_we = 1'b0;
      end
      default: begin
        if (stall) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_we    = 1'b0;
          exmem_we   = 1'b0;
          memwb_kill = 1'b1;
        end else if (taken) begin
          redirect_valid = 1'b1;
          ifid_kill      = 1'b1;
          idex_kill      = 1'b1;
          exmem_kill     = 1'b1;
        end else if (luse) begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_kill = 1'b1;
          luse_fire = 1'b1;
        end
      end
    endcase
  end

`ifdef PIPE_HAZARD_PERF_EN
  function automatic logic [0:31] sat_inc(input logic [0:31] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  logic [0:31] perf_stall_q, perf_flush_q, perf_luse_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_luse_q  <= '0;
    end else begin
      if (stall)          perf_stall_q <= sat_inc(perf_stall_q);
      if (redirect_valid) perf_flush_q <= sat_inc(perf_flush_q);
      if (luse_fire)      perf_luse_q  <= sat_inc(perf_luse_q);
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_luse_cnt  = perf_luse_q;
`endif

endmodule
